// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: the NOP encoding and
// the fetch FSM state type.
package instruction_fetch_stage_pkg;

    // All-zero word decodes as all-zero control in the ID stage.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // S_FETCH: request outstanding; S_HOLD: word captured during stall;
    // S_DRAIN: waiting for the in-flight word after a redirect.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: instruction word, PC+4 and valid flag.
// Reset and flush both load a bubble (NOP, 0, invalid); load captures a real
// instruction; with neither asserted the register holds.
module if_id_reg
    import instruction_fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              flush,
    input  logic [31:0]       next_ir,
    input  logic [ADDR_W-1:0] next_pc4,
    output logic [31:0]       ir,
    output logic [ADDR_W-1:0] pc4,
    output logic              valid
);

    // Bubble on reset or flush, capture on load, otherwise hold.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            ir    <= NOP_INSTR;
            pc4   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            ir    <= next_ir;
            pc4   <= next_pc4;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage with IF/ID register. Owns the PC and the fetch FSM,
// talks to instruction memory over a req/ack handshake, and honours stall and
// taken-branch redirects.
// Build option: define FETCH_DELAY_SLOT_EN to deliver the instruction fetched
// across a taken branch (one delay slot) instead of squashing it.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       if_id_ir,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic              if_id_valid
);

`ifdef FETCH_DELAY_SLOT_EN
    localparam logic DELAY_SLOT = 1'b1;
`else
    localparam logic DELAY_SLOT = 1'b0;
`endif

    fetch_state_t      state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [ADDR_W-1:0] target, target_nx;
    logic [31:0]       hold_ir, hold_ir_nx;
    logic [ADDR_W-1:0] hold_pc4, hold_pc4_nx;
    logic              run;

    logic              beat;
    logic              redirect;
    logic [ADDR_W-1:0] target_aligned;
    logic [ADDR_W-1:0] pc_plus4;
    logic              ifid_load, ifid_flush;
    logic [31:0]       ifid_ir_nx;
    logic [ADDR_W-1:0] ifid_pc4_nx;

    // Handshake outputs and shared datapath terms.
    always_comb begin
        imem_req       = run && (state != S_HOLD);
        imem_addr      = pc;
        beat           = imem_req && imem_ack;
        redirect       = branch_taken && !stall;
        target_aligned = branch_target & ~ADDR_W'(3);
        pc_plus4       = pc + ADDR_W'(4);
    end

    // Next-state, PC and IF/ID control. While draining, pc keeps the
    // in-flight address so imem_addr stays stable; the redirect target waits
    // in 'target' until the beat lands.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        target_nx   = target;
        hold_ir_nx  = hold_ir;
        hold_pc4_nx = hold_pc4;
        ifid_load   = 1'b0;
        ifid_flush  = 1'b0;
        ifid_ir_nx  = imem_rdata;
        ifid_pc4_nx = pc_plus4;

        case (state)
            S_FETCH: begin
                if (redirect) begin
                    ifid_flush = 1'b1;
                    if (beat || !imem_req) begin
                        pc_nx = target_aligned;
                        if (beat && DELAY_SLOT) begin
                            ifid_flush = 1'b0;
                            ifid_load  = 1'b1;
                        end
                    end else begin
                        target_nx = target_aligned;
                        state_nx  = S_DRAIN;
                    end
                end else if (beat) begin
                    pc_nx = pc_plus4;
                    if (stall) begin
                        hold_ir_nx  = imem_rdata;
                        hold_pc4_nx = pc_plus4;
                        state_nx    = S_HOLD;
                    end else begin
                        ifid_load = 1'b1;
                    end
                end else if (!stall) begin
                    ifid_flush = 1'b1;
                end
            end

            S_HOLD: begin
                if (!stall) begin
                    state_nx    = S_FETCH;
                    ifid_ir_nx  = hold_ir;
                    ifid_pc4_nx = hold_pc4;
                    hold_ir_nx  = '0;
                    hold_pc4_nx = '0;
                    if (redirect) begin
                        pc_nx = target_aligned;
                        if (DELAY_SLOT) ifid_load  = 1'b1;
                        else            ifid_flush = 1'b1;
                    end else begin
                        ifid_load = 1'b1;
                    end
                end
            end

            S_DRAIN: begin
                if (redirect) target_nx = target_aligned;
                if (beat) begin
                    pc_nx    = redirect ? target_aligned : target;
                    state_nx = S_FETCH;
                    if (DELAY_SLOT) begin
                        if (stall) begin
                            hold_ir_nx  = imem_rdata;
                            hold_pc4_nx = pc_plus4;
                            state_nx    = S_HOLD;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end else if (!stall) begin
                        ifid_flush = 1'b1;
                    end
                end else if (!stall) begin
                    ifid_flush = 1'b1;
                end
            end

            default: state_nx = S_FETCH;
        endcase
    end

    // State, PC, redirect target and hold buffer registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            target   <= RESET_PC;
            hold_ir  <= '0;
            hold_pc4 <= '0;
            run      <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            target   <= target_nx;
            hold_ir  <= hold_ir_nx;
            hold_pc4 <= hold_pc4_nx;
            run      <= 1'b1;
        end
    end

    if_id_reg #(
        .ADDR_W(ADDR_W)
    ) u_if_id_reg (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (ifid_load),
        .flush    (ifid_flush),
        .next_ir  (ifid_ir_nx),
        .next_pc4 (ifid_pc4_nx),
        .ir       (if_id_ir),
        .pc4      (if_id_pc4),
        .valid    (if_id_valid)
    );

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Randomized scoreboard bench for instruction_fetch_stage. A reactive memory
// answers requests after random delays; a program-order reference model
// predicts fetch addresses and the words that must reach IF/ID.
`timescale 1ns/1ps
module tb_instruction_fetch_stage;

    localparam int          ADDR_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    always #5 clk = ~clk;

    instruction_fetch_stage #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .if_id_ir      (if_id_ir),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid)
    );

`ifdef FETCH_DELAY_SLOT_EN
    localparam bit DELAY_SLOT = 1'b1;
`else
    localparam bit DELAY_SLOT = 1'b0;
`endif

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc4;
    } item_t;

    int    vectors = 0;
    int    miscompares = 0;
    item_t exp_q[$];

    // Reference model: next address to be fetched, pending redirect, held word.
    logic [31:0] exp_addr;
    bit          held;
    item_t       held_item;
    bit          drain;
    logic [31:0] drain_target;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[29:0], 2'b01} ^ 32'hE082_5005;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: after every edge compare IF/ID against the scoreboard.
    initial begin
        logic [31:0] e_ir, e_pc4;
        logic        e_valid;
        item_t       it;
        e_ir = '0; e_pc4 = '0; e_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                e_ir = '0; e_pc4 = '0; e_valid = 1'b0;
                check("reset_req", {31'b0, imem_req}, 32'd0);
            end else if (!stall) begin
                if (exp_q.size() > 0) begin
                    it = exp_q.pop_front();
                    e_ir = it.ir; e_pc4 = it.pc4; e_valid = 1'b1;
                end else begin
                    e_ir = '0; e_pc4 = '0; e_valid = 1'b0;
                end
            end
            check("if_id_valid", {31'b0, if_id_valid}, {31'b0, e_valid});
            check("if_id_ir", if_id_ir, e_ir);
            check("if_id_pc4", if_id_pc4, e_pc4);
        end
    end

    task automatic model_reset();
        exp_addr = RESET_PC;
        held     = 1'b0;
        drain    = 1'b0;
        exp_q.delete();
    endtask

    // Reset held for some cycles while the memory keeps acking at random.
    task automatic do_reset(input int cycles);
        reset_n      = 1'b0;
        branch_taken = 1'b0;
        stall        = 1'($urandom_range(1));
        repeat (cycles) begin
            imem_ack   = 1'($urandom_range(1));
            imem_rdata = $urandom;
            @(posedge clk);
            #2;
        end
        reset_n  = 1'b1;
        imem_ack = 1'b0;
        stall    = 1'b0;
        model_reset();
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(3))
            0:       return $urandom & 32'h0000_0FFC;
            1:       return 32'hFFFF_FFFC;
            2:       return $urandom | 32'h0000_0003;
            default: return 32'hFFFF_FFF8;
        endcase
    endfunction

    // Drive one cycle of stimulus and advance the model across the next edge.
    task automatic step(input int p_ack, input int p_stall, input int p_br);
        logic [31:0] tgt, tgt_al, nxt;
        logic        br_eff;
        item_t       it;

        check("imem_req", {31'b0, imem_req}, held ? 32'd0 : 32'd1);
        if (!held) check("imem_addr", imem_addr, exp_addr);

        imem_ack      = imem_req && ($urandom_range(99) < p_ack);
        imem_rdata    = imem_ack ? mem_word(imem_addr) : $urandom;
        stall         = ($urandom_range(99) < p_stall);
        branch_taken  = ($urandom_range(99) < p_br);
        tgt           = pick_target();
        branch_target = tgt;
        tgt_al        = {tgt[31:2], 2'b00};
        br_eff        = branch_taken && !stall;

        it.ir  = mem_word(exp_addr);
        it.pc4 = exp_addr + 32'd4;

        if (held) begin
            if (!stall) begin
                if (br_eff) begin
                    if (DELAY_SLOT) exp_q.push_back(held_item);
                    exp_addr = tgt_al;
                end else begin
                    exp_q.push_back(held_item);
                end
                held = 1'b0;
            end
        end else if (imem_ack) begin
            if (drain) begin
                nxt   = br_eff ? tgt_al : drain_target;
                drain = 1'b0;
                if (DELAY_SLOT) begin
                    if (stall) begin
                        held = 1'b1; held_item = it;
                    end else begin
                        exp_q.push_back(it);
                    end
                end
                exp_addr = nxt;
            end else if (br_eff) begin
                if (DELAY_SLOT) exp_q.push_back(it);
                exp_addr = tgt_al;
            end else begin
                if (stall) begin
                    held = 1'b1; held_item = it;
                end else begin
                    exp_q.push_back(it);
                end
                exp_addr = exp_addr + 32'd4;
            end
        end else if (br_eff) begin
            drain        = 1'b1;
            drain_target = tgt_al;
        end
    endtask

    initial begin
        int p_ack, p_stall, p_br, phase;
        model_reset();
        do_reset(3);
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk);
            #2;
            phase   = i / 500;
            p_ack   = (phase % 3 == 0) ? 100 : ((phase % 3 == 1) ? 50 : 25);
            p_stall = (phase % 4 == 0) ? 0 : ((phase % 4 == 1) ? 25 : 50);
            p_br    = (phase % 2 == 0) ? 5 : 15;
            if ($urandom_range(299) == 0) do_reset(int'($urandom_range(3, 1)));
            else step(p_ack, p_stall, p_br);
        end
        @(posedge clk);
        #2;
        imem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
